// File: rtl/display_pkg.sv
// Shared constants for the 7-segment scan controller: digit-field layout,
// idle output levels and the active-low BCD segment table.
package display_pkg;

  localparam int unsigned EN_BIT  = 5;
  localparam int unsigned BCD_MSB = 4;
  localparam int unsigned BCD_LSB = 1;
  localparam int unsigned DP_BIT  = 0;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [7:0] AN_OFF    = 8'hFF;

  // {g,f,e,d,c,b,a}, active-low; codes 10..15 render blank
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F
  };

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD to active-low 7-segment decoder.
module seg7_decoder
  import display_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  assign seg = SEG_LUT[bcd];

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller for an 8-digit common-anode 7-segment
// display with per-slot blanking gap and per-digit blink.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 100_000_000,
  parameter int unsigned REFRESH_HZ   = 1000,
  parameter int unsigned BLANK_CYCLES = 16,
  parameter int unsigned BLINK_HZ     = 2
) (
  input  logic       clk_100MHz_i,
  input  logic       reset_n_i,
  input  logic [5:0] d1_i,
  input  logic [5:0] d2_i,
  input  logic [5:0] d3_i,
  input  logic [5:0] d4_i,
  input  logic [5:0] d5_i,
  input  logic [5:0] d6_i,
  input  logic [5:0] d7_i,
  input  logic [5:0] d8_i,
  input  logic [7:0] blink_mask_i,
  output logic [7:0] an_o,
  output logic [6:0] seg_o,
  output logic       dp_o
);

  localparam int unsigned SCAN_DIV  = CLK_HZ / (8 * REFRESH_HZ);
  localparam int unsigned BLINK_DIV = CLK_HZ / (2 * BLINK_HZ);
  localparam int unsigned SCAN_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned BLINK_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  if (SCAN_DIV < BLANK_CYCLES + 2) begin : g_bad_scan_div
    $error("SCAN_DIV must be at least BLANK_CYCLES+2");
  end

  logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
  logic [2:0]         idx_q, idx_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_phase_q, blink_phase_d;

  logic [5:0] field;
  logic [6:0] seg_dec;
  logic       visible;
  logic [7:0] an_d;
  logic [6:0] seg_d;
  logic       dp_d;

  always_comb begin
    field = d1_i;
    unique case (idx_q)
      3'd0: field = d1_i;
      3'd1: field = d2_i;
      3'd2: field = d3_i;
      3'd3: field = d4_i;
      3'd4: field = d5_i;
      3'd5: field = d6_i;
      3'd6: field = d7_i;
      3'd7: field = d8_i;
    endcase
  end

  seg7_decoder u_seg7_decoder (
    .bcd (field[BCD_MSB:BCD_LSB]),
    .seg (seg_dec)
  );

  always_comb begin
    scan_cnt_d    = scan_cnt_q + SCAN_W'(1);
    idx_d         = idx_q;
    blink_cnt_d   = blink_cnt_q + BLINK_W'(1);
    blink_phase_d = blink_phase_q;

    if (scan_cnt_q == SCAN_W'(SCAN_DIV - 1)) begin
      scan_cnt_d = '0;
      idx_d      = idx_q + 3'd1;
    end
    if (blink_cnt_q == BLINK_W'(BLINK_DIV - 1)) begin
      blink_cnt_d   = '0;
      blink_phase_d = ~blink_phase_q;
    end

    // Blanking and segment selection share one decision so they switch together
    visible = field[EN_BIT] &&
              (scan_cnt_q >= SCAN_W'(BLANK_CYCLES)) &&
              !(blink_mask_i[idx_q] && !blink_phase_q);

    an_d  = AN_OFF;
    seg_d = SEG_BLANK;
    dp_d  = 1'b1;
    if (visible) begin
      an_d  = ~(8'b1 << idx_q);
      seg_d = seg_dec;
      dp_d  = field[DP_BIT];
    end
  end

  always_ff @(posedge clk_100MHz_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      scan_cnt_q    <= '0;
      idx_q         <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
      an_o          <= AN_OFF;
      seg_o         <= SEG_BLANK;
      dp_o          <= 1'b1;
    end else begin
      scan_cnt_q    <= scan_cnt_d;
      idx_q         <= idx_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      an_o          <= an_d;
      seg_o         <= seg_d;
      dp_o          <= dp_d;
    end
  end

endmodule
